// File: rtl/hawk_axird_slave_pkg.sv
// rtl/hawk_axird_slave_pkg.sv - shared types, response codes and line byteswap helper
package hawk_axird_slave_pkg;

    localparam logic [63:0] HAWK_ATT_START       = 64'h0000_0010_0000_0000;
    localparam logic [1:0]  HACD_AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0]  HACD_AXI_RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  arlen;
        logic        arvalid;
        logic        rready;
    } axi_rd_reqpkt_t;

    typedef struct packed {
        logic arready;
    } axi_rd_rdypkt_t;

    typedef struct packed {
        logic [1:0]   rresp;
        logic [511:0] rdata;
        logic         rvalid;
        logic         rlast;
    } axi_rd_resppkt_t;

    // Reverses byte order inside each 64-bit word of a 64-byte line.
    function automatic logic [511:0] get_8byte_byteswap(input logic [511:0] d);
        logic [511:0] r;
        r = '0;
        for (int w = 0; w < 8; w++) begin
            for (int b = 0; b < 8; b++) begin
                r[w*64 + b*8 +: 8] = d[w*64 + (7-b)*8 +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/hawk_axird_slave_if.sv
// rtl/hawk_axird_slave_if.sv - AXI read request/ready/response bundle with initiator and target views
interface hawk_axird_slave_if;
    import hawk_axird_slave_pkg::*;

    axi_rd_reqpkt_t  rd_req_i;
    axi_rd_rdypkt_t  rd_rdy_o;
    axi_rd_resppkt_t rd_resp_o;

    modport slave (
        input  rd_req_i,
        output rd_rdy_o,
        output rd_resp_o
    );

    modport master (
        output rd_req_i,
        input  rd_rdy_o,
        input  rd_resp_o
    );
endinterface

// File: rtl/hawk_axird_slave_sram.sv
// rtl/hawk_axird_slave_sram.sv - hawk_sram_1r1w: registered-read, read-first line store, not reset
module hawk_sram_1r1w #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 512
) (
    input  logic                     clk,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Same-edge read and write of one entry returns the pre-write contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/hawk_axird_slave.sv
// rtl/hawk_axird_slave.sv - AXI read target serving 64-byte lines from a backdoor-loaded store
module hawk_axird_slave
    import hawk_axird_slave_pkg::*;
#(
    parameter int unsigned DEPTH     = 64,
    parameter logic [63:0] BASE_ADDR = HAWK_ATT_START
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    hawk_axird_slave_if.slave        rd_bus,
    input  logic                     bd_we_i,
    input  logic [$clog2(DEPTH)-1:0] bd_idx_i,
    input  logic [511:0]             bd_wdata_i,
    output logic                     busy_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, BEAT} state_t;

    state_t       state;
    logic [63:0]  idx;
    logic [7:0]   beats_left;
    logic         below_base;
    logic         arready_q;
    logic         rvalid_q;
    logic         rlast_q;
    logic         ok_q;
    logic [1:0]   rresp_q;
    logic         in_range;
    logic         sram_re;
    logic [511:0] sram_q;
    logic [511:0] rdata_w;

    // Range is judged on the full 64-bit line index so a long burst never wraps back into the store.
    assign in_range = !below_base && (idx < 64'(DEPTH));
    assign sram_re  = (state == FETCH) && in_range;
    assign rdata_w  = (rvalid_q && ok_q) ? get_8byte_byteswap(sram_q) : '0;
    assign busy_o   = (state != IDLE);

    assign rd_bus.rd_rdy_o  = axi_rd_rdypkt_t'(arready_q);
    assign rd_bus.rd_resp_o = '{rresp: rresp_q, rdata: rdata_w, rvalid: rvalid_q, rlast: rlast_q};

    hawk_sram_1r1w #(.DEPTH(DEPTH), .WIDTH(512)) u_sram (
        .clk   (clk_i),
        .re    (sram_re),
        .raddr (idx[AW-1:0]),
        .rdata (sram_q),
        .we    (bd_we_i),
        .waddr (bd_idx_i),
        .wdata (bd_wdata_i)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            idx        <= '0;
            beats_left <= '0;
            below_base <= 1'b0;
            arready_q  <= 1'b1;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            ok_q       <= 1'b0;
            rresp_q    <= HACD_AXI_RESP_OKAY;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_bus.rd_req_i.arvalid) begin
                        idx        <= (rd_bus.rd_req_i.addr - BASE_ADDR) >> 6;
                        below_base <= (rd_bus.rd_req_i.addr < BASE_ADDR);
                        beats_left <= rd_bus.rd_req_i.arlen;
                        arready_q  <= 1'b0;
                        state      <= FETCH;
                    end
                end
                FETCH: begin
                    ok_q     <= in_range;
                    rresp_q  <= in_range ? HACD_AXI_RESP_OKAY : HACD_AXI_RESP_SLVERR;
                    rlast_q  <= (beats_left == 8'd0);
                    rvalid_q <= 1'b1;
                    state    <= BEAT;
                end
                BEAT: begin
                    if (rd_bus.rd_req_i.rready) begin
                        rvalid_q <= 1'b0;
                        rlast_q  <= 1'b0;
                        rresp_q  <= HACD_AXI_RESP_OKAY;
                        ok_q     <= 1'b0;
                        if (rlast_q) begin
                            arready_q <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            idx        <= idx + 64'd1;
                            beats_left <= beats_left - 8'd1;
                            state      <= FETCH;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    arready_q <= 1'b1;
                    rvalid_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule
